// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squashes,
// multi-cycle data-memory waits with timeout, plus saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       dec_ra,
  input  logic [1:0]       dec_rb,
  input  logic             dec_uses_ra,
  input  logic             dec_uses_rb,
  input  logic             ex_mem_read,
  input  logic [1:0]       ex_ra,
  input  logic             br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             cnt_clr,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             id_stall,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              load_use;
  logic              br_event;
  logic              freeze;

  assign load_use = ex_mem_read &
                    ((dec_uses_ra & (dec_ra == ex_ra)) |
                     (dec_uses_rb & (dec_rb == ex_ra)));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    id_stall   = 1'b0;
    idex_hold  = 1'b0;
    exmem_hold = 1'b0;
    br_event   = 1'b0;
    freeze     = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (dmem_req && !dmem_ack) begin
            freeze     = 1'b1;
            state_d    = MEM_WAIT;
            wait_cnt_d = WC_W'(1);
          end else if (br_taken) begin
            // Squash the wrong-path fetch and decode; a pending load-use is moot.
            ifid_flush = 1'b1;
            id_stall   = 1'b1;
            br_event   = 1'b1;
          end else if (load_use) begin
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
            id_stall  = 1'b1;
          end
        end
        MEM_WAIT: begin
          // On ack or on the last allowed cycle the holds drop so the pipeline advances now.
          if (dmem_ack) begin
            state_d    = RUN;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
            state_d    = RUN;
            wait_cnt_d = '0;
            mem_err_d  = 1'b1;
          end else begin
            freeze     = 1'b1;
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end
        default: state_d = RUN;
      endcase
      if (freeze) begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_hold  = 1'b1;
        exmem_hold = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (pc_hold && !(&stall_cnt_q))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (br_event && !(&flush_cnt_q))
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
